// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - SPI SCK generator with CPOL/CPHA edge, sample and shift strobes
// Optional macro SCK_PAUSE_EN adds a pause input that freezes the generator in RUN/TAIL.
module spi_sck_gen #(
  parameter int DIV_W    = 8,
  parameter int MAX_BITS = 32,
  localparam int CNT_W   = $clog2(MAX_BITS + 1)
) (
  input  logic             clk_100,
  input  logic             s_rst,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] nbits,
  input  logic             cpol,
  input  logic             cpha,
`ifdef SCK_PAUSE_EN
  input  logic             pause,
`endif
  output logic             busy,
  output logic             done,
  output logic             sck,
  output logic             lead_edge,
  output logic             trail_edge,
  output logic             sample_stb,
  output logic             shift_stb
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TAIL, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_hc, w_hc_nxt, r_div_l, w_div_nxt;
  logic [CNT_W:0]   r_ec, w_ec_nxt, w_ec_inc, w_ec_last;
  logic [CNT_W-1:0] r_nbits_l, w_nbits_nxt, w_nbits_clamp;
  logic             r_cpol_l, w_cpol_nxt, r_cpha_l, w_cpha_nxt;
  logic             r_sck, w_sck_nxt, r_busy, w_busy_nxt, r_done, w_done_nxt;
  logic             r_lead, w_lead_nxt, r_trail, w_trail_nxt;
  logic             r_sample, w_sample_nxt, r_shift, w_shift_nxt;
  logic             w_pause;

`ifdef SCK_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_ec_inc      = r_ec + (CNT_W+1)'(1);
  assign w_ec_last     = {r_nbits_l, 1'b0};
  assign w_nbits_clamp = (nbits > CNT_W'(MAX_BITS)) ? CNT_W'(MAX_BITS) : nbits;

  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      r_state   <= S_IDLE;
      r_hc      <= '0;
      r_ec      <= '0;
      r_div_l   <= '0;
      r_nbits_l <= '0;
      r_cpol_l  <= 1'b0;
      r_cpha_l  <= 1'b0;
      r_sck     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_lead    <= 1'b0;
      r_trail   <= 1'b0;
      r_sample  <= 1'b0;
      r_shift   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hc      <= w_hc_nxt;
      r_ec      <= w_ec_nxt;
      r_div_l   <= w_div_nxt;
      r_nbits_l <= w_nbits_nxt;
      r_cpol_l  <= w_cpol_nxt;
      r_cpha_l  <= w_cpha_nxt;
      r_sck     <= w_sck_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_lead    <= w_lead_nxt;
      r_trail   <= w_trail_nxt;
      r_sample  <= w_sample_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hc_nxt     = r_hc;
    w_ec_nxt     = r_ec;
    w_div_nxt    = r_div_l;
    w_nbits_nxt  = r_nbits_l;
    w_cpol_nxt   = r_cpol_l;
    w_cpha_nxt   = r_cpha_l;
    w_sck_nxt    = r_sck;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_lead_nxt   = 1'b0;
    w_trail_nxt  = 1'b0;
    w_sample_nxt = 1'b0;
    w_shift_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sck_nxt = cpol;
        if (start && (nbits != '0)) begin
          w_div_nxt   = div;
          w_nbits_nxt = w_nbits_clamp;
          w_cpol_nxt  = cpol;
          w_cpha_nxt  = cpha;
          w_hc_nxt    = '0;
          w_ec_nxt    = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_pause) begin
          if (r_hc == r_div_l) begin
            w_sck_nxt   = ~r_sck;
            w_hc_nxt    = '0;
            w_ec_nxt    = w_ec_inc;
            // Odd edge numbers are leading edges, even ones trailing.
            w_lead_nxt  = w_ec_inc[0];
            w_trail_nxt = ~w_ec_inc[0];
            if (r_cpha_l) begin
              w_sample_nxt = ~w_ec_inc[0];
              w_shift_nxt  = w_ec_inc[0];
            end else begin
              w_sample_nxt = w_ec_inc[0];
              w_shift_nxt  = ~w_ec_inc[0] && (w_ec_inc != w_ec_last);
            end
            if (w_ec_inc == w_ec_last) begin
              w_state_nxt = S_TAIL;
            end
          end else begin
            w_hc_nxt = r_hc + DIV_W'(1);
          end
        end
      end
      S_TAIL: begin
        if (!w_pause) begin
          if (r_hc == r_div_l) begin
            w_hc_nxt    = '0;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_hc_nxt = r_hc + DIV_W'(1);
          end
        end
      end
      // One cycle that carries the done pulse; a start seen here is not accepted.
      S_DONE: begin
        w_sck_nxt   = r_cpol_l;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign sck        = r_sck;
  assign lead_edge  = r_lead;
  assign trail_edge = r_trail;
  assign sample_stb = r_sample;
  assign shift_stb  = r_shift;

endmodule

// File: tb/tb_spi_sck_gen.sv
// tb/tb_spi_sck_gen.sv - randomized self-checking bench for spi_sck_gen
// Model predicts each edge from the count of unpaused burst cycles; SCK_PAUSE_EN enables random pauses.
module tb_spi_sck_gen;
  localparam int DIV_W    = 8;
  localparam int MAX_BITS = 32;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);

  logic             clk_100 = 1'b0;
  logic             s_rst, start, cpol, cpha, pause;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] nbits;
  logic             busy, done, sck, lead_edge, trail_edge, sample_stb, shift_stb;
  int               n_cmp = 0;
  int               n_err = 0;

  always #5 clk_100 = ~clk_100;

  spi_sck_gen #(.DIV_W(DIV_W), .MAX_BITS(MAX_BITS)) dut (
    .clk_100    (clk_100),
    .s_rst      (s_rst),
    .start      (start),
    .div        (div),
    .nbits      (nbits),
    .cpol       (cpol),
    .cpha       (cpha),
`ifdef SCK_PAUSE_EN
    .pause      (pause),
`endif
    .busy       (busy),
    .done       (done),
    .sck        (sck),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .sample_stb (sample_stb),
    .shift_stb  (shift_stb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input logic e_busy, input logic e_done, input logic e_sck,
                            input logic e_lead, input logic e_trail,
                            input logic e_samp, input logic e_shift);
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("sck", 32'(sck), 32'(e_sck));
    check("lead_edge", 32'(lead_edge), 32'(e_lead));
    check("trail_edge", 32'(trail_edge), 32'(e_trail));
    check("sample_stb", 32'(sample_stb), 32'(e_samp));
    check("shift_stb", 32'(shift_stb), 32'(e_shift));
  endtask

  task automatic idle_follow(input int cycles);
    logic c;
    for (int i = 0; i < cycles; i++) begin
      c = 1'($urandom_range(0, 1));
      start = 1'b0;
      cpol  = c;
      @(negedge clk_100);
      check_outs(1'b0, 1'b0, c, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic zero_start();
    start = 1'b1;
    nbits = '0;
    div   = DIV_W'($urandom);
    cpol  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_100);
      check("nbits0_busy", 32'(busy), 32'd0);
      check("nbits0_done", 32'(done), 32'd0);
    end
    start = 1'b0;
  endtask

  // Entered and left at a negedge. Edge e (1..2*nl) becomes visible the cycle after the
  // e*(d+1)-th unpaused burst cycle; done follows after (2*nl+1)*(d+1) such cycles.
  task automatic run_burst(input int d, input int n, input bit cp, input bit ch, input int rst_at);
    int   nl, act, e, bound, pauses;
    bit   p, fin;
    logic e_busy, e_done, e_sck, e_lead, e_trail, e_samp, e_shift, c2;
    nl     = (n > MAX_BITS) ? MAX_BITS : n;
    start  = 1'b1;
    div    = DIV_W'(d);
    nbits  = CNT_W'(n);
    cpol   = cp;
    cpha   = ch;
    pause  = 1'b0;
    e_busy = 1'b1; e_done = 1'b0; e_sck = cp;
    e_lead = 1'b0; e_trail = 1'b0; e_samp = 1'b0; e_shift = 1'b0;
    act    = 0;
    pauses = 0;
    fin    = 1'b0;
    bound  = (2 * nl + 1) * (d + 1) + 40;
    for (int j = 1; j <= bound && !fin; j++) begin
      @(negedge clk_100);
      check_outs(e_busy, e_done, e_sck, e_lead, e_trail, e_samp, e_shift);
      if (e_done) begin
        fin = 1'b1;
      end else if (j == rst_at) begin
        s_rst = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        @(negedge clk_100);
        check_outs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        s_rst = 1'b0;
        c2    = 1'($urandom_range(0, 1));
        cpol  = c2;
        @(negedge clk_100);
        check_outs(1'b0, 1'b0, c2, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end else begin
        start = 1'($urandom_range(0, 1));
        div   = DIV_W'($urandom);
        nbits = CNT_W'($urandom);
        cpol  = 1'($urandom_range(0, 1));
        cpha  = 1'($urandom_range(0, 1));
`ifdef SCK_PAUSE_EN
        p = (pauses < 20) && ($urandom_range(0, 3) == 0);
`else
        p = 1'b0;
`endif
        pause = p;
        if (p) pauses++;
        e_lead = 1'b0; e_trail = 1'b0; e_samp = 1'b0; e_shift = 1'b0;
        if (!p) begin
          act++;
          if (act % (d + 1) == 0) begin
            e = act / (d + 1);
            if (e <= 2 * nl) begin
              e_sck   = ~e_sck;
              e_lead  = (e % 2 == 1);
              e_trail = (e % 2 == 0);
              e_samp  = ch ? e_trail : e_lead;
              e_shift = ch ? e_lead : (e_trail && (e != 2 * nl));
            end else begin
              e_done = 1'b1;
              e_busy = 1'b0;
            end
          end
        end
      end
    end
    if (!fin) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    // A start presented while done is high must be ignored.
    start = 1'b1;
    nbits = CNT_W'(1);
    cpol  = 1'($urandom_range(0, 1));
    pause = 1'b0;
    @(negedge clk_100);
    check_outs(1'b0, 1'b0, cp, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int d, n, nl, r;
    s_rst = 1'b1; start = 1'b0; div = '0; nbits = '0;
    cpol  = 1'b1; cpha  = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clk_100);
    check_outs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    s_rst = 1'b0;
    idle_follow(3);
    run_burst(1, 2, 1'b0, 1'b0, 0);
    run_burst(0, 8, 1'b1, 1'b1, 0);
    idle_follow(2);
    run_burst(3, 4, 1'b0, 1'b1, 0);
    run_burst(1, 4, 1'b0, 1'b0, 10);
    run_burst(1, 4, 1'b1, 1'b0, 0);
    zero_start();
    run_burst(0, 40, 1'b0, 1'b0, 0);
    run_burst(255, 1, 1'b1, 1'b0, 0);
    for (int k = 0; k < 30; k++) begin
      d  = $urandom_range(0, 6);
      n  = $urandom_range(1, 40);
      nl = (n > MAX_BITS) ? MAX_BITS : n;
      r  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2 * nl * (d + 1)) : 0;
      run_burst(d, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
      if ($urandom_range(0, 2) == 0) idle_follow(2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
